// File: rtl/divn_tick_sched.sv
// divn_tick_sched: divide-by-N tick generator controller.
// Holds a programmable divisor, sequences IDLE/RUN/DRAIN and shares each
// tick round-robin among NREQ requesters.
// Optional feature macro: DIVN_TICK_SCHED_TICKCNT_EN adds the tick_count
// output, a saturating count of ticks since the last start.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | stopped, phase held at 0, divisor writes accepted
// S_RUN   | phase counting 0..div_reg-1, tick on phase 0
// S_DRAIN | stop requested, finishing current period without ticks
module divn_tick_sched #(
    parameter int W    = 4,
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_valid,
    input  logic [W-1:0]    cfg_div,
    output logic            cfg_ready,
    input  logic            start,
    input  logic            stop,
    input  logic [NREQ-1:0] req,
    output logic            tick,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic [W-1:0]    phase,
`ifdef DIVN_TICK_SCHED_TICKCNT_EN
    output logic [7:0]      tick_count,
`endif
    output logic            err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  div_reg;
    logic [W-1:0]  phase_nxt;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] cand_idx;
    logic          gnt_any;
    logic          wr_en;
    logic          wr_ok;
    logic          start_ok;
    logic          phase_last;
    int            cand;

    // An illegal write in the same cycle as start blocks the start.
    assign wr_en      = cfg_valid && cfg_ready;
    assign wr_ok      = (cfg_div >= W'(2));
    assign start_ok   = start && !(wr_en && !wr_ok);
    assign phase_last = (phase == (div_reg - W'(1)));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and next phase; phase returns to 0 whenever IDLE is entered.
    always_comb begin
        state_nxt = S_IDLE;
        phase_nxt = '0;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_RUN;
            end
            S_RUN: begin
                phase_nxt = phase_last ? '0 : (phase + W'(1));
                if (stop && phase_last) begin
                    state_nxt = S_IDLE;
                    phase_nxt = '0;
                end else if (stop) begin
                    state_nxt = S_DRAIN;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (phase_last) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_DRAIN;
                    phase_nxt = phase + W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs plus round-robin grant scan starting at rr_ptr.
    always_comb begin
        tick      = (state == S_RUN) && (phase == '0);
        busy      = (state != S_IDLE);
        cfg_ready = (state == S_IDLE);
        gnt       = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = PW'(cand);
            if (tick && !gnt_any && req[cand_idx]) begin
                gnt_any       = 1'b1;
                gnt_idx       = cand_idx;
                gnt[cand_idx] = 1'b1;
            end
        end
    end

    // Phase counter.
    always_ff @(posedge clk) begin
        if (reset) phase <= '0;
        else       phase <= phase_nxt;
    end

    // Divisor register and sticky illegal-divisor flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= W'(3);
            err     <= 1'b0;
        end else if (wr_en) begin
            if (wr_ok) begin
                div_reg <= cfg_div;
                err     <= 1'b0;
            end else begin
                err     <= 1'b1;
            end
        end
    end

    // Round-robin pointer moves past the granted requester; holds otherwise.
    always_ff @(posedge clk) begin
        if (reset)        rr_ptr <= '0;
        else if (gnt_any) rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : (gnt_idx + PW'(1));
    end

`ifdef DIVN_TICK_SCHED_TICKCNT_EN
    // Saturating tick counter, restarted on every IDLE->RUN transition.
    always_ff @(posedge clk) begin
        if (reset)                                  tick_count <= '0;
        else if (state == S_IDLE && start_ok)       tick_count <= '0;
        else if (tick && tick_count != 8'd255)      tick_count <= tick_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_divn_tick_sched.sv
// Bench for divn_tick_sched: stimulus pushes expected tick cycles and grants
// into queues; a negedge monitor pops and compares on every tick.
module tb_divn_tick_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_div = '0;
    logic       cfg_ready;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] req = '0;
    logic       tick;
    logic [2:0] gnt;
    logic       busy;
    logic [3:0] phase;
    logic       err;
`ifdef DIVN_TICK_SCHED_TICKCNT_EN
    logic [7:0] tick_count;
`endif

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int cyc      = 0;

    int         exp_cyc_q[$];
    logic [2:0] exp_gnt_q[$];
    logic [2:0] exp_g[8];
    logic [2:0] exp_req[8];

    divn_tick_sched #(.W(4), .NREQ(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .start     (start),
        .stop      (stop),
        .req       (req),
        .tick      (tick),
        .gnt       (gnt),
        .busy      (busy),
        .phase     (phase),
`ifdef DIVN_TICK_SCHED_TICKCNT_EN
        .tick_count(tick_count),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every tick must match the head of the expectation queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (tick === 1'b1) begin
                vec_cnt++;
                if (exp_cyc_q.size() == 0) begin
                    miss_cnt++;
                    $display("FAIL unexpected_tick: tick at cycle %0d gnt=%b, none expected", cyc, gnt);
                end else begin
                    int         ec;
                    logic [2:0] eg;
                    ec = exp_cyc_q.pop_front();
                    eg = exp_gnt_q.pop_front();
                    if (ec != cyc || gnt !== eg) begin
                        miss_cnt++;
                        $display("FAIL tick_gnt: got cycle %0d gnt=%b, expected cycle %0d gnt=%b",
                                 cyc, gnt, ec, eg);
                    end
                end
            end else if (gnt !== 3'b000) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL gnt_no_tick: got gnt=%b at cycle %0d, expected 000", gnt, cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt + 1);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        vec_cnt++;
        if (act != exp_v) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic cfg_write(input logic [3:0] d);
        cfg_valid = 1'b1;
        cfg_div   = d;
        step(1);
        cfg_valid = 1'b0;
    endtask

    // Start, expect nt ticks every div cycles using exp_g/exp_req, then stop
    // exactly on the last phase so the block returns straight to IDLE.
    task automatic do_run(input int div, input int nt);
        int s;
        s = cyc;
        for (int k = 0; k < nt; k++) begin
            exp_cyc_q.push_back(s + 1 + k * div);
            exp_gnt_q.push_back(exp_g[k]);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("busy_run", int'(busy), 1);
        chk("cfg_ready_run", int'(cfg_ready), 0);
        for (int k = 0; k < nt; k++) begin
            wait_until(s + 1 + k * div);
            req = exp_req[k];
            if (k == 0) begin
                step(1);
                chk("phase_first", int'(phase), 1);
                wait_until(s + div);
                chk("phase_last", int'(phase), div - 1);
            end
        end
        wait_until(s + nt * div);
        chk("phase_before_stop", int'(phase), div - 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("busy_after_stop", int'(busy), 0);
        chk("phase_after_stop", int'(phase), 0);
        chk("cfg_ready_after_stop", int'(cfg_ready), 1);
    endtask

    initial begin
        int s;
        step(2);
        reset = 1'b0;
        step(1);
        chk("rst_tick", int'(tick), 0);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_phase", int'(phase), 0);
        chk("rst_err", int'(err), 0);

        // Default divisor 3, all requesting: 001,010,100,001 (ptr -> 1).
        exp_req = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        do_run(3, 4);

        // Illegal divisor: err set, divisor stays 3 (ptr 1 -> 010,100; ptr -> 0).
        cfg_write(4'd1);
        chk("err_illegal", int'(err), 1);
        chk("cfg_ready_illegal", int'(cfg_ready), 1);
        exp_g[0] = 3'b010; exp_g[1] = 3'b100;
        do_run(3, 2);
        chk("err_sticky", int'(err), 1);

        // Legal divisor 2 clears err.
        cfg_write(4'd2);
        chk("err_cleared", int'(err), 0);
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
        do_run(2, 3);

        // Divisor 5.
        cfg_write(4'd5);
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
        do_run(5, 3);

        // Request patterns at divisor 3: 010 (ptr->2), 101 -> 100 (ptr->0),
        // 101 -> 001 (ptr->1), none -> 000 (ptr holds 1), 111 -> 010 (ptr->2).
        cfg_write(4'd3);
        exp_req[0] = 3'b010; exp_req[1] = 3'b101; exp_req[2] = 3'b101;
        exp_req[3] = 3'b000; exp_req[4] = 3'b111;
        exp_g[0] = 3'b010; exp_g[1] = 3'b100; exp_g[2] = 3'b001;
        exp_g[3] = 3'b000; exp_g[4] = 3'b010;
        do_run(3, 5);

        // Divisor 4, stop at phase 1 -> DRAIN through phases 2,3, then IDLE.
        req = 3'b111;
        cfg_write(4'd4);
        s = cyc;
        exp_cyc_q.push_back(s + 1);
        exp_gnt_q.push_back(3'b100);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        chk("drain_phase_at_stop", int'(phase), 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("drain_busy", int'(busy), 1);
        chk("drain_phase2", int'(phase), 2);
        chk("drain_tick", int'(tick), 0);
        chk("drain_cfg_ready", int'(cfg_ready), 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("drain_phase3", int'(phase), 3);
        chk("drain_busy3", int'(busy), 1);
        step(1);
        chk("drain_end_busy", int'(busy), 0);
        chk("drain_end_cfg_ready", int'(cfg_ready), 1);
        chk("drain_end_phase", int'(phase), 0);

        // Illegal divisor together with start: stays IDLE, err set.
        cfg_valid = 1'b1;
        cfg_div   = 4'd0;
        start     = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        start     = 1'b0;
        chk("ill_start_err", int'(err), 1);
        chk("ill_start_busy", int'(busy), 0);
        chk("ill_start_tick", int'(tick), 0);
        step(3);
        chk("ill_start_still_idle", int'(busy), 0);

        // Reset in the middle of DRAIN (divisor 4, ptr 0 -> 001).
        s = cyc;
        exp_cyc_q.push_back(s + 1);
        exp_gnt_q.push_back(3'b001);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("mid_drain_busy", int'(busy), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst2_busy", int'(busy), 0);
        chk("rst2_phase", int'(phase), 0);
        chk("rst2_tick", int'(tick), 0);
        chk("rst2_cfg_ready", int'(cfg_ready), 1);
        chk("rst2_err", int'(err), 0);

        // After reset: divisor back to 3, pointer back to 0.
        exp_req = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
        exp_g[0] = 3'b001; exp_g[1] = 3'b010;
        do_run(3, 2);

        step(4);
        chk("queue_drained", exp_cyc_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/divn_tick_sched.md
Name: divn_tick_sched

Overview:
Controller for the team's divide-by-N tick generator. Holds a runtime-programmable divisor and sequences the divider through idle, run and drain phases. Shares each generated tick round-robin among NREQ requesters. Sits between the configuration bus and the consumers of periodic strobes.

Parameters:
W, 4, divisor and phase counter width (bits)
NREQ, 3, number of tick requesters (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  divisor write request
cfg_div  input  W  requested divisor N
cfg_ready  output  1  divisor write accepted when high with cfg_valid
start  input  1  begin ticking
stop  input  1  request graceful stop
req  input  NREQ  per-requester tick request, level
tick  output  1  one-cycle strobe, once per N cycles while running
gnt  output  NREQ  one-hot grant, valid only in tick cycles
busy  output  1  high in RUN and DRAIN
phase  output  W  current phase count
err  output  1  sticky: last accepted divisor was illegal

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset, applied at any time including mid-RUN/DRAIN: next edge gives state=IDLE, div_reg=3, phase=0, rr pointer=0, err=0. Resulting outputs: tick=0, gnt=0, busy=0, cfg_ready=1, phase=0.
- States: IDLE, RUN, DRAIN (2-bit encoding; unused code returns to IDLE).
- cfg_ready=1 only in IDLE.
- Divisor write (cfg_valid && cfg_ready):
  - cfg_div>=2: div_reg<=cfg_div, err<=0.
  - cfg_div<2: div_reg unchanged, err<=1. err stays set until the next legal write.
- IDLE -> RUN on start, with phase<=0.
  - If cfg_valid && start occur in the same cycle, the write is applied first. RUN then uses the new divisor.
  - If that write is illegal, start is ignored and the block stays in IDLE.
- RUN: phase increments each cycle and wraps from div_reg-1 to 0.
- tick = (state==RUN && phase==0). It is a Moore output decoded from registers. The first tick occurs in the cycle after start is sampled, and the period is exactly div_reg cycles.
- gnt (combinational; nonzero only while tick=1):
  - Grants the first asserted req scanning from the rr pointer upward, modulo NREQ. The pointer then becomes granted index+1, modulo NREQ.
  - No req asserted: gnt=0 and the pointer holds.
- RUN + stop:
  - If phase==div_reg-1: next state IDLE, phase<=0.
  - Otherwise: next state DRAIN, phase keeps counting.
- DRAIN: no ticks. On phase==div_reg-1, next state IDLE with phase<=0.
- start is ignored in RUN and DRAIN. stop is ignored in IDLE. If start and stop are both asserted in IDLE, start wins.
- busy = (state!=IDLE). phase is held at 0 in IDLE.
- Arithmetic is unsigned, width W. Maximum divisor is 2^W-1. phase never exceeds div_reg-1.

Optional Feature:
DIVN_TICK_SCHED_TICKCNT_EN
- Defined: adds output tick_count[7:0].
  - Cleared to 0 on reset and on each IDLE->RUN transition.
  - Increments on every tick and saturates at 255.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then start with default div=3, req=3'b111 -> tick in cycles 1,4,7,10 after start; gnt sequence 001,010,100,001.
- In IDLE, write cfg_div=5, then start -> tick every 5 cycles; phase runs 0..4.
- Write cfg_div=1 -> err=1, div_reg stays 3; then write cfg_div=2 -> err=0, ticks every 2 cycles.
- div=4, stop asserted at phase=1 -> DRAIN through phases 2,3 with no tick; IDLE at the next edge; busy falls; cfg_ready rises.
- req=3'b010 only, then 3'b101 -> gnt 010 on the first tick (pointer->2), then 100, then 001; req=0 on a tick -> gnt=0, pointer unchanged.
- Reset asserted mid-DRAIN, and cfg_div=0 with start in the same cycle -> both return/stay IDLE with tick=0; start is ignored and err=1.
